// File: rtl/sseg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner: steps through the digits of a
// double-buffered display word and drives registered active-low anodes and cathodes.
module sseg_scanner #(
  parameter int DIGITS        = 8,
  parameter int PRESCALE      = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  en,
  output logic [3:0]            hex,
  input  logic [6:0]            sseg_in,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame
);

  localparam int PC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef struct packed {
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
  } word_t;

  word_t             pending;
  word_t             shown;
  logic [PC_W-1:0]   pc;
  logic [IDX_W-1:0]  idx;
  logic              slot_end;
  logic              last_digit;
  logic              blank;
  logic              dp_cur;
  logic [DIGITS-1:0] digit_sel;

  assign slot_end   = (pc == PC_LAST);
  assign last_digit = (idx == IDX_LAST);

  // Select the current digit and decide leading-zero blanking by scanning from
  // the most significant nibble down, so upper_zero covers nibbles idx..DIGITS-1.
  always_comb begin
    logic upper_zero;
    // NOTE: blocking assignments with a default first keep this purely combinational (no latch).
    hex        = 4'h0;
    blank      = 1'b0;
    dp_cur     = 1'b0;
    digit_sel  = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (shown.value[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        digit_sel[i] = 1'b1;
        hex          = shown.value[4*i +: 4];
        dp_cur       = shown.dp[i];
        blank        = BLANK_LEADING && (i != 0) && upper_zero;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments; reset is synchronous and wins over load and en.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending <= '0;
      shown   <= '0;
      pc      <= '0;
      idx     <= '0;
      an_n    <= '1;
      seg_n   <= '1;
      dp_n    <= 1'b1;
      frame   <= 1'b0;
    end else begin
      if (load) pending <= {value, dp};

      if (!en) begin
        pc    <= '0;
        idx   <= '0;
        shown <= pending;
        an_n  <= '1;
        seg_n <= '1;
        dp_n  <= 1'b1;
        frame <= 1'b0;
      end else begin
        an_n  <= ~digit_sel;
        seg_n <= blank ? 7'h7F : ~sseg_in;
        dp_n  <= ~dp_cur;
        frame <= slot_end && last_digit;
        if (slot_end) begin
          pc <= '0;
          if (last_digit) begin
            idx   <= '0;
            shown <= pending;   // swap only at the wrap so a frame never tears
          end else begin
            idx <= idx + 1'b1;
          end
        end else begin
          pc <= pc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_scanner.sv
// Bench for sseg_scanner (4 digits, 4-cycle slots) with a hex-to-7-segment
// converter in the loop and a time-based reference model of the display.
module tb_sseg_scanner;

  localparam int D     = 4;
  localparam int P     = 4;
  localparam int FRAME = D * P;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        load  = 1'b0;
  logic        en    = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp    = '0;
  logic [3:0]  hex;
  logic [6:0]  sseg_in;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  sseg_scanner #(.DIGITS(D), .PRESCALE(P), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rstn(rstn), .value(value), .dp(dp), .load(load), .en(en),
    .hex(hex), .sseg_in(sseg_in), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
    .frame(frame)
  );

  // Hex-to-7-segment converter, active-high, bit6 = a .. bit0 = g.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
      4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
      4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
      4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
    endcase
  endfunction

  assign sseg_in = seg7(hex);

  function automatic logic [3:0] nib(input logic [15:0] w, input int d);
    return 4'((w >> (4 * d)) & 16'hF);
  endfunction

  // Reference model: the lit digit follows from how many enabled cycles have
  // elapsed since the scan (re)started; the word swaps every FRAME enabled cycles.
  int unsigned m_t;
  int          m_d;
  logic [15:0] m_pend_v, m_shown_v;
  logic [3:0]  m_pend_dp, m_shown_dp;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_frame;

  task automatic model_edge();
    int d;
    if (!rstn) begin
      m_pend_v = '0; m_pend_dp = '0; m_shown_v = '0; m_shown_dp = '0;
      m_t = 0; m_d = -1;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
      return;
    end
    if (!en) begin
      m_shown_v = m_pend_v; m_shown_dp = m_pend_dp;
      m_t = 0; m_d = -1;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
    end else begin
      d     = int'((m_t / P) % D);
      m_d   = d;
      e_an  = ~(4'b0001 << d);
      e_seg = (d != 0 && (m_shown_v >> (4 * d)) == 16'h0) ? 7'h7F : ~seg7(nib(m_shown_v, d));
      e_dp  = ~m_shown_dp[d];
      m_t++;
      e_frame = (m_t % FRAME) == 0;
      if (e_frame) begin
        m_shown_v = m_pend_v; m_shown_dp = m_pend_dp;
      end
    end
    if (load) begin
      m_pend_v = value; m_pend_dp = dp;
    end
  endtask

  function automatic logic [16:0] obs();
    return {an_n, seg_n, dp_n, frame, hex};
  endfunction

  function automatic logic [16:0] expv();
    int d = int'((m_t / P) % D);
    return {e_an, e_seg, e_dp, e_frame, nib(m_shown_v, d)};
  endfunction

  // One clock: update the model from the inputs seen at the edge, then settle.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; load = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) rstn = 1'b1;
      tick();
      checks++;
      if (obs() !== {4'hF, 7'h7F, 1'b1, 1'b0, 4'h0}) begin
        fails++;
        $display("FAIL reset_idle k=%0d got=%h required=%h", k, obs(), {4'hF, 7'h7F, 1'b1, 1'b0, 4'h0});
      end
    end
  endtask

  task automatic test_scan_order();
    int first_frame, n_frames;
    value = 16'h1234; dp = 4'h0; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    en = 1'b1;
    first_frame = -1; n_frames = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL scan_model k=%0d got=%h exp=%h", k, obs(), expv());
      end
      checks++;
      if (an_n !== ~(4'b0001 << (((k - 1) / P) % D)) || seg_n !== ~seg7(4'(4 - m_d))) begin
        fails++;
        $display("FAIL scan_order k=%0d an_n=%b seg_n=%h required an_n=%b seg_n=%h",
                 k, an_n, seg_n, ~(4'b0001 << (((k - 1) / P) % D)), ~seg7(4'(4 - m_d)));
      end
      if (frame === 1'b1) begin
        n_frames++;
        if (first_frame < 0) first_frame = k;
      end
    end
    checks++;
    if (first_frame != FRAME || n_frames != 2) begin
      fails++;
      $display("FAIL frame_period first=%0d count=%0d required first=%0d count=2", first_frame, n_frames, FRAME);
    end
  endtask

  task automatic test_blanking();
    logic [6:0] want_seg;
    logic       want_dp;
    for (int pass = 0; pass < 2; pass++) begin
      en = 1'b0; load = 1'b1;
      value = (pass == 0) ? 16'h0050 : 16'h0000;
      dp    = (pass == 0) ? 4'b1000  : 4'b0000;
      tick();
      load = 1'b0;
      tick();
      en = 1'b1;
      for (int k = 0; k < FRAME; k++) begin
        tick();
        checks++;
        if (obs() !== expv()) begin
          fails++; $display("FAIL blank_model pass=%0d k=%0d got=%h exp=%h", pass, k, obs(), expv());
        end
        case (m_d)
          3:       begin want_seg = 7'h7F;        want_dp = (pass == 0) ? 1'b0 : 1'b1; end
          2:       begin want_seg = 7'h7F;        want_dp = 1'b1; end
          1:       begin want_seg = (pass == 0) ? ~seg7(4'h5) : 7'h7F; want_dp = 1'b1; end
          default: begin want_seg = ~seg7(4'h0);  want_dp = 1'b1; end
        endcase
        checks++;
        if (seg_n !== want_seg || dp_n !== want_dp) begin
          fails++;
          $display("FAIL blank_digit pass=%0d digit=%0d seg_n=%h dp_n=%b required seg_n=%h dp_n=%b",
                   pass, m_d, seg_n, dp_n, want_seg, want_dp);
        end
      end
    end
  endtask

  task automatic test_tear_free();
    bit seen;
    en = 1'b0; value = 16'h1234; dp = 4'h0; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    en = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    value = 16'hAAAA; load = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 2 * FRAME && !seen; k++) begin
      tick();
      load = 1'b0;
      checks++;
      if (obs() !== expv() || seg_n !== ~seg7(nib(16'h1234, m_d))) begin
        fails++;
        $display("FAIL tear_old k=%0d got=%h exp=%h seg_n=%h required=%h",
                 k, obs(), expv(), seg_n, ~seg7(nib(16'h1234, m_d)));
      end
      seen = e_frame;
    end
    checks++;
    if (!seen) begin
      fails++; $display("FAIL tear_wrap_timeout got=no_frame required=frame");
    end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      checks++;
      if (obs() !== expv() || seg_n !== ~seg7(4'hA)) begin
        fails++;
        $display("FAIL tear_new k=%0d got=%h exp=%h seg_n=%h required=%h", k, obs(), expv(), seg_n, ~seg7(4'hA));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] word;
    for (int k = 0; k < FRAME && ((m_t + 1) % FRAME) != 0; k++) tick();
    value = 16'hBEEF; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (frame !== 1'b1) begin
      fails++; $display("FAIL wrap_load_frame got=%b required=1", frame);
    end
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      word = (k < FRAME) ? 16'hAAAA : 16'hBEEF;
      checks++;
      if (obs() !== expv() || seg_n !== ~seg7(nib(word, m_d))) begin
        fails++;
        $display("FAIL wrap_load k=%0d got=%h exp=%h seg_n=%h required=%h",
                 k, obs(), expv(), seg_n, ~seg7(nib(word, m_d)));
      end
    end
  endtask

  task automatic test_reset_midscan();
    for (int k = 0; k < FRAME && (m_t % FRAME) != 9; k++) tick();
    checks++;
    if ((m_t % FRAME) != 9 || an_n !== 4'b1011) begin
      fails++; $display("FAIL midscan_position an_n=%b required=1011", an_n);
    end
    rstn = 1'b0; value = 16'h1234; load = 1'b1;
    tick();
    checks++;
    if (obs() !== {4'hF, 7'h7F, 1'b1, 1'b0, 4'h0}) begin
      fails++; $display("FAIL midscan_reset got=%h required=%h", obs(), {4'hF, 7'h7F, 1'b1, 1'b0, 4'h0});
    end
    rstn = 1'b1; load = 1'b0;
    tick();
    checks++;
    if (an_n !== 4'b1110 || seg_n !== 7'h01 || dp_n !== 1'b1) begin
      fails++;
      $display("FAIL midscan_restart an_n=%b seg_n=%h dp_n=%b required an_n=1110 seg_n=01 dp_n=1", an_n, seg_n, dp_n);
    end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL midscan_model k=%0d got=%h exp=%h", k, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1200; k++) begin
      value = 16'($urandom) >> (4 * $urandom_range(0, 3));
      dp    = 4'($urandom);
      load  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
      rstn  = ($urandom_range(0, 299) != 0);
      tick();
      checks++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL random k=%0d got=%h exp=%h", k, obs(), expv());
      end
    end
    rstn = 1'b1; load = 1'b0;
  endtask

  initial begin
    m_t = 0; m_d = -1;
    m_pend_v = '0; m_pend_dp = '0; m_shown_v = '0; m_shown_dp = '0;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
    test_reset();
    test_scan_order();
    test_blanking();
    test_tear_free();
    test_back_to_back();
    test_reset_midscan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
